seq_serializer: RTL

- Parallel-to-serial front end that produces the single-bit stream consumed by the downstream sequence detector on its seq_in.
- Accepts DATA_W-bit words over a valid/ready handshake and shifts them out one bit per clock.
- Holds one word while another is shifting, so back-to-back words stream with no idle bit between them.
- Drives a fixed IDLE_BIT whenever no word is shifting. The detector samples every cycle, so the output is always defined.

---
 rtl/seq_serializer_if.sv | 23 ++
 rtl/seq_serializer.sv | 116 +++++++++++
 2 files changed

// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bundle for the serializer. The upstream producer and the
// downstream detector tap the master side; the serializer sits on the slave side.
interface seq_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              seq_out;
  logic              seq_valid;
  logic              busy;
  logic              word_done;

  modport master (
    output data_in, data_valid,
    input  data_ready, seq_out, seq_valid, busy, word_done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, seq_out, seq_valid, busy, word_done
  );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end. A shifter plus one hold register keep
// back-to-back words streaming with no idle bit between them. seq_out,
// seq_valid and word_done are registered, so nothing combinational reaches
// the detector.
module seq_serializer #(
  parameter int   DATA_W    = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_serializer_if.slave  bus
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic [DATA_W-1:0] hold, hold_nxt;
  logic              hold_full, hold_full_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              out_q, vld_q, done_q;
  logic              out_nxt, vld_nxt, done_nxt;
  logic              last, xfer;

  // Ready depends only on the hold flag, so upstream never sees a loop
  // through data_valid.
  assign xfer = bus.data_valid && !hold_full;
  assign last = (state == SHIFT) && (cnt == LAST_CNT);

  assign bus.data_ready = ~hold_full;
  assign bus.busy       = (state == SHIFT) | hold_full;
  assign bus.seq_out    = out_q;
  assign bus.seq_valid  = vld_q;
  assign bus.word_done  = done_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: idle only when the last bit leaves with nothing queued behind it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (xfer) state_nxt = SHIFT;
      SHIFT: if (last && !hold_full && !xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: a word loads into the shifter when it is idle or on its last bit
  // (hold word first), otherwise it parks in the hold register.
  always_comb begin
    sh_nxt        = sh;
    cnt_nxt       = cnt;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    if (state == IDLE || last) begin
      if (last && hold_full) begin
        sh_nxt        = hold;
        cnt_nxt       = '0;
        hold_full_nxt = 1'b0;
      end else if (xfer) begin
        sh_nxt  = bus.data_in;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = '0;
      end
    end else begin
      if (MSB_FIRST != 0) sh_nxt = {sh[DATA_W-2:0], 1'b0};
      else                sh_nxt = {1'b0, sh[DATA_W-1:1]};
      cnt_nxt = cnt + 1'b1;
      if (xfer) begin
        hold_nxt      = bus.data_in;
        hold_full_nxt = 1'b1;
      end
    end
  end

  // Output decode from next-cycle state, registered below.
  always_comb begin
    out_nxt  = IDLE_BIT;
    vld_nxt  = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == SHIFT) begin
      out_nxt  = (MSB_FIRST != 0) ? sh_nxt[DATA_W-1] : sh_nxt[0];
      vld_nxt  = 1'b1;
      done_nxt = (cnt_nxt == LAST_CNT);
    end
  end

  // Datapath and output registers; reset discards any partial or held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      out_q     <= IDLE_BIT;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sh        <= sh_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      out_q     <= out_nxt;
      vld_q     <= vld_nxt;
      done_q    <= done_nxt;
    end
  end
endmodule
